i2c_reg_reader: RTL and testbench
=================================

Name: i2c_reg_reader

Overview:
- Command sequencer that sits directly upstream of i2c_master and drives its ena/addr/rw/data_wr handshake.
- Performs one "register read" transaction per request:
  - write one register-index byte to a 7-bit device address;
  - repeated start;
  - read 1..MAX_BYTES bytes.
- Packs the bytes into a result word and returns them with a done pulse and an error flag.
- Replaces hand-written busy-edge FSMs in sensor/peripheral polling top levels.

Parameters:
- MAX_BYTES, 4: maximum read length; rdata width = 8*MAX_BYTES.
- TIMEOUT_CYCLES, 4800000: watchdog limit in clk cycles (100 ms at 48 MHz). Used only with I2C_RR_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (48 MHz).
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; accepted only when ready=1.
- dev_addr  in  7  target device address; sampled on accept.
- reg_addr  in  8  register index to write; sampled on accept.
- num_bytes  in  3  bytes to read; sampled on accept.
- ready  out  1  FSM in IDLE and i2c_busy=0.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of transaction, success or failure.
- error  out  1  NACK (or timeout) seen in last transaction; valid with done, held until next accept.
- timeout  out  1  last transaction ended by watchdog; tied 0 without I2C_RR_TIMEOUT_EN.
- rdata  out  8*MAX_BYTES  read bytes; byte k in rdata[8k+7:8k].
- i2c_ena  out  1  to i2c_master ena.
- i2c_addr  out  7  to i2c_master addr.
- i2c_rw  out  1  to i2c_master rw (1 = read).
- i2c_wdata  out  8  to i2c_master data_wr.
- i2c_busy  in  1  from i2c_master busy.
- i2c_data_rd  in  8  from i2c_master data_rd.
- i2c_ack_error  in  1  from i2c_master ack_error.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE;
  - all outputs 0, including rdata and i2c_*;
  - internal busy_d=0, counters 0.
- Edge detection: busy_d registers i2c_busy each cycle.
  - rise = i2c_busy & ~busy_d.
  - fall = ~i2c_busy & busy_d.
- n = num_bytes clamped on accept: 0 -> 1; values above MAX_BYTES -> MAX_BYTES.
- IDLE:
  - start & ready -> accept. Next cycle:
    - i2c_ena=1, i2c_rw=0, i2c_addr=dev_addr, i2c_wdata=reg_addr;
    - rdata=0, error=0, timeout=0, busy=1;
    - go W_ADDR.
  - start while not ready is ignored; no done is issued.
- W_ADDR: on rise (master has latched the write):
  - i2c_rw<=1, i2c_ena stays 1;
  - cmd_cnt<=0, fall_cnt<=0; go RD.
- RD:
  - Each rise (master latched a read command): cmd_cnt<=cmd_cnt+1. If cmd_cnt+1 == n, then i2c_ena<=0 so the master stops after byte n.
  - Each fall: fall_cnt<=fall_cnt+1.
    - fall_cnt=0 is the end of the register-index write; no capture.
    - fall_cnt=k (1..n): rdata byte k-1 <= i2c_data_rd.
    - After capturing byte n, go FIN.
  - A rise and a fall in the same cycle cannot occur (single busy line); no priority rule is needed.
- Error, in W_ADDR or RD: i2c_ack_error=1 sampled on any fall -> error<=1, i2c_ena<=0, go DRAIN.
- DRAIN: wait for i2c_busy=0 for one cycle, then go FIN. Bytes already captured are retained.
- FIN: done=1 for exactly one cycle, busy=0, go IDLE.
- Latency (not counting the I2C bus):
  - accept -> i2c_ena high: 1 cycle.
  - final fall -> done: 1 cycle.
- Reset mid-transaction: immediately drops i2c_ena; no done pulse. i2c_master must be reset by the same reset_n.

Optional Feature:
- Macro I2C_RR_TIMEOUT_EN.
- Defined:
  - a 32-bit watchdog counts cycles in W_ADDR/RD/DRAIN and clears on any rise or fall;
  - reaching TIMEOUT_CYCLES -> i2c_ena<=0, error<=1, timeout<=1, go FIN directly (done still pulses once);
  - counter is 0 in IDLE.
- Undefined: no watchdog logic; timeout output is constant 0.

Test Plan:
- Read 2 bytes: dev_addr=0x25, reg_addr=0x00, num_bytes=2, model returns 0xA5, 0x3C -> write byte 0x00 with rw=0, then two reads; rdata[15:0]=0x3CA5, rdata[31:16]=0, done one cycle, error=0.
- num_bytes=0 and num_bytes=7 (MAX_BYTES=4) -> exactly 1 and 4 read bytes issued respectively; i2c_ena low after the last rise.
- Model NACKs the address byte -> error=1, done once after i2c_busy low, rdata=0, ready returns to 1.
- start pulsed while i2c_busy=1, and while a transaction is running -> ignored; no extra done; the running transaction's rdata is unchanged.
- reset_n asserted mid-RD after 1 byte -> all outputs 0 on the same edge; a new request completes normally afterwards.
- With I2C_RR_TIMEOUT_EN and TIMEOUT_CYCLES=100, model holds busy high forever -> 100 cycles after the last edge: done=1, error=1, timeout=1.

Source files
------------

// File: rtl/i2c_reg_reader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_reg_reader
//
// Command sequencer placed directly upstream of i2c_master. One request
// performs a register read: write the register index to a 7-bit device,
// repeated start, then read 1..MAX_BYTES bytes. The bytes are packed into
// rdata (byte k in rdata[8k+7:8k]) and returned with a one-cycle done pulse
// and an error flag.
//
// Optional feature: define I2C_RR_TIMEOUT_EN to add a 32-bit watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles without any i2c_busy edge.
// Without the macro the timeout output is tied low.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   start               request pulse, accepted only while ready=1
//   dev_addr/reg_addr   device address / register index, sampled on accept
//   num_bytes           bytes to read (0 -> 1, above MAX_BYTES -> MAX_BYTES)
//   ready, busy         idle-and-bus-free / transaction in progress
//   done, error         end-of-transaction pulse / NACK or timeout seen
//   timeout             last transaction ended by the watchdog
//   rdata               packed read bytes
//   i2c_ena/addr/rw/wdata   command handshake towards i2c_master
//   i2c_busy/data_rd/ack_error  status from i2c_master
// ---------------------------------------------------------------------------
module i2c_reg_reader #(
  parameter int MAX_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 4800000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [6:0]             dev_addr,
  input  logic [7:0]             reg_addr,
  input  logic [2:0]             num_bytes,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   timeout,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   i2c_ena,
  output logic [6:0]             i2c_addr,
  output logic                   i2c_rw,
  output logic [7:0]             i2c_wdata,
  input  logic                   i2c_busy,
  input  logic [7:0]             i2c_data_rd,
  input  logic                   i2c_ack_error
);

  localparam int CW = $clog2(MAX_BYTES + 2);

  typedef enum logic [2:0] {IDLE, W_ADDR, RD, DRAIN, FIN} state_t;

  state_t                 state_q;
  logic                   idle_q;
  logic                   busyDly_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic [8*MAX_BYTES-1:0] rdata_q;
  logic                   ena_q;
  logic [6:0]             addr_q;
  logic                   rw_q;
  logic [7:0]             wdata_q;
  logic [CW-1:0]          nBytes_q;
  logic [CW-1:0]          cmdCnt_q;
  logic [CW-1:0]          fallCnt_q;

  logic busyRise;
  logic busyFall;
  logic accept;
  logic wdogExpired;

  // Requested length folded into 1..MAX_BYTES.
  function automatic logic [CW-1:0] clampLen(input logic [2:0] req);
    if (req == 3'd0) begin
      return CW'(1);
    end else if (int'(req) > MAX_BYTES) begin
      return CW'(MAX_BYTES);
    end else begin
      return CW'(req);
    end
  endfunction

  // A rising i2c_busy means the master latched the current command; a
  // falling one means the byte it was working on has finished.
  assign busyRise = i2c_busy & ~busyDly_q;
  assign busyFall = ~i2c_busy & busyDly_q;

  // idle_q stays low during and right after reset so ready reads 0 there.
  assign ready  = idle_q & ~i2c_busy;
  assign accept = (state_q == IDLE) & start & ready;

`ifdef I2C_RR_TIMEOUT_EN
  logic [31:0] wdog_q;
  logic        timeout_q;

  // Fires on the cycle the edge-free count reaches TIMEOUT_CYCLES.
  assign wdogExpired = (state_q inside {W_ADDR, RD, DRAIN}) && !busyRise && !busyFall &&
                       (wdog_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout     = timeout_q;

  // Watchdog counts only while a transaction is waiting on the bus and
  // restarts on every busy edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q inside {W_ADDR, RD, DRAIN}) begin
        wdog_q <= (busyRise || busyFall) ? 32'd0 : wdog_q + 32'd1;
      end else begin
        wdog_q <= '0;
      end
      if (accept) begin
        timeout_q <= 1'b0;
      end else if (wdogExpired) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unusedTimeoutLimit;

  assign wdogExpired        = 1'b0;
  assign timeout            = 1'b0;
  assign unusedTimeoutLimit = ^32'(TIMEOUT_CYCLES);
`endif

  // Main sequencer: every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idle_q    <= 1'b0;
      busyDly_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      ena_q     <= 1'b0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      nBytes_q  <= '0;
      cmdCnt_q  <= '0;
      fallCnt_q <= '0;
    end else begin
      busyDly_q <= i2c_busy;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          idle_q <= 1'b1;
          if (accept) begin
            idle_q    <= 1'b0;
            ena_q     <= 1'b1;
            rw_q      <= 1'b0;
            addr_q    <= dev_addr;
            wdata_q   <= reg_addr;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b1;
            nBytes_q  <= clampLen(num_bytes);
            cmdCnt_q  <= '0;
            fallCnt_q <= '0;
            state_q   <= W_ADDR;
          end
        end

        W_ADDR: begin
          if (wdogExpired) begin
            ena_q   <= 1'b0;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end else if (busyFall && i2c_ack_error) begin
            error_q <= 1'b1;
            ena_q   <= 1'b0;
            state_q <= DRAIN;
          end else if (busyRise) begin
            // Index write latched: the next command the master takes is a read.
            rw_q      <= 1'b1;
            cmdCnt_q  <= '0;
            fallCnt_q <= '0;
            state_q   <= RD;
          end
        end

        RD: begin
          if (wdogExpired) begin
            ena_q   <= 1'b0;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end else if (busyFall && i2c_ack_error) begin
            error_q <= 1'b1;
            ena_q   <= 1'b0;
            state_q <= DRAIN;
          end else if (busyRise) begin
            cmdCnt_q <= cmdCnt_q + CW'(1);
            // Dropping ena right after the n-th read is latched makes the
            // master stop after that byte.
            if (cmdCnt_q + CW'(1) == nBytes_q) begin
              ena_q <= 1'b0;
            end
          end else if (busyFall) begin
            // Fall 0 closes the index write; fall k delivers read byte k-1.
            fallCnt_q <= fallCnt_q + CW'(1);
            for (int b = 0; b < MAX_BYTES; b++) begin
              if (fallCnt_q == CW'(b + 1)) begin
                rdata_q[8*b +: 8] <= i2c_data_rd;
              end
            end
            if (fallCnt_q == nBytes_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FIN;
            end
          end
        end

        DRAIN: begin
          if (wdogExpired) begin
            ena_q   <= 1'b0;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end else if (!i2c_busy) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FIN;
          end
        end

        FIN: begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign rdata     = rdata_q;
  assign i2c_ena   = ena_q;
  assign i2c_addr  = addr_q;
  assign i2c_rw    = rw_q;
  assign i2c_wdata = wdata_q;

endmodule

// File: tb/tb_i2c_reg_reader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2c_reg_reader
//
// Drives i2c_reg_reader against a behavioural i2c_master stand-in and checks
// results against expectations computed from the register-read rules:
// clamped length, expected command list, packed read data, error and done.
// With I2C_RR_TIMEOUT_EN defined the watchdog path is exercised as well.
// ---------------------------------------------------------------------------
module tb_i2c_reg_reader;

  localparam int MAXB = 4;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
  } cmd_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            start = 1'b0;
  logic [6:0]      dev_addr = '0;
  logic [7:0]      reg_addr = '0;
  logic [2:0]      num_bytes = '0;
  logic            ready, busy, done, error, timeout;
  logic [8*MAXB-1:0] rdata;
  logic            i2c_ena;
  logic [6:0]      i2c_addr;
  logic            i2c_rw;
  logic [7:0]      i2c_wdata;
  logic            i2c_busy = 1'b0;
  logic [7:0]      i2c_data_rd = '0;
  logic            i2c_ack_error = 1'b0;

  int total = 0;
  int bad = 0;
  int doneCount = 0;

  logic [7:0] rdBytes [8];
  int         readIdx = 0;
  int         readFalls = 0;
  cmd_t       cmdLog [$];
  bit         nackFirst = 1'b0;
  bit         forceBusy = 1'b0;
  bit         hangBusy = 1'b0;
  int         mPhase = 0;
  int         mTimer = 0;
  logic       mRw = 1'b0;
  longint     edgeTime = 0;

  i2c_reg_reader #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .num_bytes(num_bytes), .ready(ready), .busy(busy),
    .done(done), .error(error), .timeout(timeout), .rdata(rdata),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_wdata(i2c_wdata), .i2c_busy(i2c_busy), .i2c_data_rd(i2c_data_rd),
    .i2c_ack_error(i2c_ack_error)
  );

  // 100 MHz-style free-running clock.
  initial forever #5 clk = ~clk;

  // Counts every cycle in which done is high.
  always @(negedge clk) if (done) doneCount <= doneCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Master stand-in: latches a command when it sees ena, raises busy, then
  // drops busy with the byte result and decides whether to continue.
  task automatic modelLatch();
    cmdLog.push_back({i2c_addr, i2c_rw, i2c_wdata});
    mRw           = i2c_rw;
    i2c_ack_error = 1'b0;
    i2c_busy      = 1'b1;
    edgeTime      = $time;
    mPhase        = 1;
    mTimer        = $urandom_range(2, 5);
  endtask

  initial begin : masterModel
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        i2c_busy      = 1'b0;
        i2c_ack_error = 1'b0;
        mPhase        = 0;
      end else begin
        case (mPhase)
          0: begin
            if (i2c_ena) modelLatch();
            else i2c_busy = forceBusy;
          end
          1: begin
            if (!hangBusy) begin
              mTimer--;
              if (mTimer == 0) begin
                if (mRw) begin
                  i2c_data_rd = rdBytes[readIdx];
                  readIdx++;
                  readFalls++;
                end else begin
                  i2c_data_rd = 8'($urandom);
                end
                i2c_ack_error = nackFirst && !mRw;
                i2c_busy      = 1'b0;
                edgeTime      = $time;
                mPhase        = 2;
                mTimer        = $urandom_range(1, 3);
              end
            end
          end
          default: begin
            mTimer--;
            if (mTimer == 0) begin
              if (i2c_ena) modelLatch();
              else mPhase = 0;
            end
          end
        endcase
      end
    end
  end

  function automatic int expLen(input int req);
    if (req == 0) return 1;
    if (req > MAXB) return MAXB;
    return req;
  endfunction

  task automatic fillRandom();
    for (int k = 0; k < 8; k++) rdBytes[k] = 8'($urandom);
  endtask

  task automatic waitReady(input string tag);
    int cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput({tag, "_ready"}, 64'(ready), 64'd1);
  endtask

  // One full register read from request to done, checked against the
  // expected command list and packed data.
  task automatic applyStimulus(input logic [6:0] dev, input logic [7:0] rg, input logic [2:0] nb,
                               input bit nack, input bit pokeMid, input string tag);
    int n;
    int cnt;
    int startDone;
    int expCmds;
    logic [8*MAXB-1:0] expRdata;
    waitReady(tag);
    readIdx   = 0;
    readFalls = 0;
    cmdLog.delete();
    nackFirst = nack;
    n         = expLen(int'(nb));
    expRdata  = '0;
    if (!nack) for (int k = 0; k < n; k++) expRdata[8*k +: 8] = rdBytes[k];
    expCmds   = nack ? 1 : n + 1;
    startDone = doneCount;
    dev_addr  = dev;
    reg_addr  = rg;
    num_bytes = nb;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_ena"}, 64'(i2c_ena), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    checkOutput({tag, "_rw0"}, 64'(i2c_rw), 64'd0);
    checkOutput({tag, "_rdclr"}, 64'(rdata), 64'd0);
    checkOutput({tag, "_errclr"}, 64'(error), 64'd0);
    if (pokeMid) begin
      repeat (4) @(negedge clk);
      dev_addr  = ~dev;
      reg_addr  = ~rg;
      num_bytes = 3'd1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cnt = 0;
    while (done !== 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_rdata"}, 64'(rdata), 64'(expRdata));
    checkOutput({tag, "_error"}, 64'(error), 64'(nack));
    checkOutput({tag, "_timeout"}, 64'(timeout), 64'd0);
    checkOutput({tag, "_busyend"}, 64'(busy), 64'd0);
    checkOutput({tag, "_enaend"}, 64'(i2c_ena), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 64'(done), 64'd0);
    repeat (6) @(negedge clk);
    checkOutput({tag, "_readyend"}, 64'(ready), 64'd1);
    checkOutput({tag, "_errhold"}, 64'(error), 64'(nack));
    checkOutput({tag, "_ndone"}, 64'(doneCount - startDone), 64'd1);
    checkOutput({tag, "_ncmd"}, 64'(cmdLog.size()), 64'(expCmds));
    for (int k = 0; k < cmdLog.size(); k++) begin
      checkOutput({tag, "_cmd"}, 64'(cmdLog[k]),
                  64'({dev, (k != 0), (k == 0) ? rg : cmdLog[k].wdata}));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 64'(ready), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_error"}, 64'(error), 64'd0);
    checkOutput({tag, "_timeout"}, 64'(timeout), 64'd0);
    checkOutput({tag, "_rdata"}, 64'(rdata), 64'd0);
    checkOutput({tag, "_i2c"}, 64'({i2c_ena, i2c_addr, i2c_rw, i2c_wdata}), 64'd0);
  endtask

  // Directed steps followed by randomized transactions.
  initial begin : mainSeq
    int cnt;
    int startDone;
    #1 reset_n = 1'b0;
    #2 checkAllZero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] two-byte read");
    rdBytes[0] = 8'hA5;
    rdBytes[1] = 8'h3C;
    applyStimulus(7'h25, 8'h00, 3'd2, 1'b0, 1'b0, "rd2");

    $display("[TB] length clamping");
    fillRandom();
    applyStimulus(7'h11, 8'h42, 3'd0, 1'b0, 1'b0, "len0");
    fillRandom();
    applyStimulus(7'h6A, 8'h99, 3'd7, 1'b0, 1'b0, "len7");

    $display("[TB] address NACK");
    fillRandom();
    applyStimulus(7'h30, 8'h05, 3'd2, 1'b1, 1'b0, "nack");

    $display("[TB] start ignored while master busy");
    startDone = doneCount;
    forceBusy = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("ign_ready", 64'(ready), 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("ign_busy", 64'(busy), 64'd0);
    checkOutput("ign_ena", 64'(i2c_ena), 64'd0);
    forceBusy = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("ign_ndone", 64'(doneCount - startDone), 64'd0);

    $display("[TB] start ignored mid-transaction");
    fillRandom();
    applyStimulus(7'h52, 8'h1F, 3'd3, 1'b0, 1'b1, "poke");

    $display("[TB] reset during read phase");
    fillRandom();
    waitReady("rst");
    readIdx   = 0;
    readFalls = 0;
    nackFirst = 1'b0;
    cmdLog.delete();
    dev_addr  = 7'h0C;
    reg_addr  = 8'h77;
    num_bytes = 3'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (readFalls < 1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("rst_firstbyte", 64'(readFalls), 64'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 checkAllZero("rstmid");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    fillRandom();
    applyStimulus(7'h0C, 8'h77, 3'd3, 1'b0, 1'b0, "afterrst");

    $display("[TB] randomized transactions");
    for (int t = 0; t < 8; t++) begin
      fillRandom();
      applyStimulus(7'($urandom_range(0, 127)), 8'($urandom), 3'($urandom_range(0, 7)),
                    1'b0, 1'b0, "rand");
    end

`ifdef I2C_RR_TIMEOUT_EN
    $display("[TB] watchdog");
    begin
      longint delta;
      fillRandom();
      waitReady("wd");
      readIdx   = 0;
      nackFirst = 1'b0;
      hangBusy  = 1'b1;
      dev_addr  = 7'h44;
      reg_addr  = 8'h10;
      num_bytes = 3'd2;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (done !== 1'b1 && cnt < 400) begin
        @(negedge clk);
        cnt++;
      end
      delta = ($time - edgeTime) / 10;
      checkOutput("wd_done", 64'(done), 64'd1);
      checkOutput("wd_error", 64'(error), 64'd1);
      checkOutput("wd_timeout", 64'(timeout), 64'd1);
      checkOutput("wd_delay", 64'(delta >= 99 && delta <= 102), 64'd1);
      hangBusy = 1'b0;
      repeat (15) @(negedge clk);
      checkOutput("wd_ready", 64'(ready), 64'd1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
